four_bit_adder_top: RTL and testbench
=====================================

// Module: four_bit_adder_top
// PURPOSE
//   Board-level 4-bit adder with carry-in for a switch/button lab board.
//   Operand A = {Sw3,Sw2,Sw1,Sw0}, operand B = {Sw7,Sw6,Sw5,Sw4}, carry-in = Btn0.
//   Produces the registered 5-bit sum (carry-out in bit 4) for LEDs.
//   Top of the adder design; instantiates a ripple-carry chain of full adders.
// PARAMETERS
//   WIDTH      4   operand width; Output is WIDTH+1 bits (fixed 4 for this board)
//   SYNC_STAGES 2  flops per input synchronizer (used only with ADDER_INPUT_SYNC_EN)
// PORTS
//   clk     in   1  single system clock, rising-edge
//   rst_n   in   1  reset, asynchronous assert, active-low
//   Sw0..Sw3 in  1  operand A bits 0..3 (Sw0 = LSB)
//   Sw4..Sw7 in  1  operand B bits 0..3 (Sw4 = LSB)
//   Btn0    in   1  carry-in (1 = add one)
//   Output  out  5  {carry_out, sum[3:0]} = A + B + Btn0
// BEHAVIOUR
//   - One clock; reset asynchronous, active-low: rst_n=0 immediately forces
//     Output=5'b00000 and clears all internal flops; release is sampled on clk.
//   - Arithmetic: unsigned, Output = A + B + Btn0, range 0..31, never wraps
//     (max 15+15+1 = 31 = 5'b11111). Bit 4 is the ripple carry-out.
//   - Output is a register, updated every rising clk edge from current inputs;
//     no enable, no handshake. Held stable between edges.
//   - Latency (input change -> Output): 1 cycle without sync, 1+SYNC_STAGES
//     cycles with sync (3 at default).
//   - Inputs changing every cycle: each edge reflects the inputs sampled at that
//     edge (after sync delay); no filtering or debounce.
//   - Reset mid-operation: Output returns to 0 at once; after release first
//     valid sum appears after the normal latency (sync flops restart at 0).
//   - No X propagation: all flops have reset values.
// CONFIGURATION
//   ADDER_INPUT_SYNC_EN defined: every Sw*/Btn0 passes through a SYNC_STAGES-deep
//     flop synchronizer (reset to 0) before the adder; latency 1+SYNC_STAGES.
//   Not defined: inputs feed the adder directly; latency 1 cycle. Sum values
//     identical in both builds.
// STRUCTURE
//   Shared package adder_pkg: localparam ADD_WIDTH=4, SUM_WIDTH=ADD_WIDTH+1,
//     typedef logic [ADD_WIDTH-1:0] operand_t, logic [SUM_WIDTH-1:0] sum_t.
//   Sub-module full_adder (a,b,cin -> s,cout), instantiated WIDTH times via
//     generate as a ripple chain; top holds operand packing, optional
//     synchronizers and the output register.
// TESTING
//   1. rst_n=0, all inputs 0 -> Output=0 asynchronously; stays 0 after release.
//   2. A=0, B=0, Btn0=0 -> Output=5'b00000 after latency.
//   3. Sw1=Sw3=1 (A=10), Sw4=Sw7=1 (B=9), Btn0=0 -> Output=19 (5'b10011);
//      then Btn0=1 -> Output=20 (5'b10100) one latency later.
//   4. All Sw=1, Btn0=1 -> Output=31 (5'b11111); Btn0=0 -> 30 (carry-out set).
//   5. A=15, B=1, Btn0=0 -> 16 (5'b10000), full carry ripple through all stages.
//   6. Assert rst_n while Output=31 -> 0 immediately, no clock needed; check
//      exact latency (1 vs 3 cycles) in both ADDER_INPUT_SYNC_EN builds.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and widths for the board-level ripple-carry adder.
// Operands are 4 bits wide; the sum carries one extra bit for carry-out.
package adder_pkg;

  localparam int ADD_WIDTH = 4;
  localparam int SUM_WIDTH = ADD_WIDTH + 1;

  typedef logic [ADD_WIDTH-1:0] operand_t;
  typedef logic [SUM_WIDTH-1:0] sum_t;

  // Everything the adder consumes in one cycle; also the unit of synchronisation
  typedef struct packed {
    logic     cin;
    operand_t b;
    operand_t a;
  } adder_in_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder, purely combinational; one link of the ripple chain.
// No state, no flow control.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/four_bit_adder_top.sv
// Switch/button 4-bit adder with registered 5-bit sum; latency 1 cycle, or 1+SYNC_STAGES
// with ADDER_INPUT_SYNC_EN defined. No backpressure: the output updates every clk edge.
module four_bit_adder_top
  import adder_pkg::*;
#(
  parameter int WIDTH       = ADD_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic Sw0,
  input  logic Sw1,
  input  logic Sw2,
  input  logic Sw3,
  input  logic Sw4,
  input  logic Sw5,
  input  logic Sw6,
  input  logic Sw7,
  input  logic Btn0,
  output sum_t Output
);

  // The board wiring and the package types pin the width; catch bad overrides early
  if (WIDTH != ADD_WIDTH) begin : g_bad_width
    $error("four_bit_adder_top: WIDTH must equal ADD_WIDTH");
  end
  if (SYNC_STAGES < 1) begin : g_bad_sync
    $error("four_bit_adder_top: SYNC_STAGES must be at least 1");
  end

  adder_in_t raw_in;
  adder_in_t add_in;

  assign raw_in.a   = {Sw3, Sw2, Sw1, Sw0};
  assign raw_in.b   = {Sw7, Sw6, Sw5, Sw4};
  assign raw_in.cin = Btn0;

`ifdef ADDER_INPUT_SYNC_EN
  adder_in_t sync_q [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= raw_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign add_in = sync_q[SYNC_STAGES-1];
`else
  assign add_in = raw_in;
`endif

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_bits;

  assign carry[0] = add_in.cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    full_adder u_fa (
      .a    (add_in.a[i]),
      .b    (add_in.b[i]),
      .cin  (carry[i]),
      .s    (sum_bits[i]),
      .cout (carry[i+1])
    );
  end

  sum_t sum_d;
  sum_t sum_q;

  assign sum_d = {carry[WIDTH], sum_bits};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign Output = sum_q;

endmodule

// File: tb/tb_four_bit_adder_top.sv
// Directed bench for four_bit_adder_top; expected sums are hand-computed.
// Latency expectation follows ADDER_INPUT_SYNC_EN.
module tb_four_bit_adder_top;

`ifdef ADDER_INPUT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] a_drv;
  logic [3:0] b_drv;
  logic       btn;
  logic [4:0] out_w;

  int errors = 0;
  int checks = 0;
  logic [4:0] prev_exp;

  four_bit_adder_top dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .Sw0    (a_drv[0]),
    .Sw1    (a_drv[1]),
    .Sw2    (a_drv[2]),
    .Sw3    (a_drv[3]),
    .Sw4    (b_drv[0]),
    .Sw5    (b_drv[1]),
    .Sw6    (b_drv[2]),
    .Sw7    (b_drv[3]),
    .Btn0   (btn),
    .Output (out_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  // Drive at a falling edge, then confirm the old value holds for LAT-1 edges
  // and the new value appears exactly at edge LAT.
  task automatic apply(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic c, input logic [4:0] exp_v);
    @(negedge clk);
    a_drv = a;
    b_drv = b;
    btn   = c;
    for (int i = 1; i <= LAT; i++) begin
      @(negedge clk);
      if (i < LAT) check({tag, "_hold"}, out_w, prev_exp);
      else         check(tag, out_w, exp_v);
    end
    prev_exp = exp_v;
  endtask

  initial begin
    rst_n = 1'b1;
    a_drv = 4'd0;
    b_drv = 4'd0;
    btn   = 1'b0;
    prev_exp = 5'd0;

    #1 rst_n = 1'b0;
    #1 check("reset_async", out_w, 5'b00000);
    repeat (2) @(negedge clk);
    check("reset_held", out_w, 5'b00000);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("after_release", out_w, 5'b00000);
    end

    apply("zero",        4'd0,  4'd0,  1'b0, 5'b00000);
    apply("a10_b9",      4'd10, 4'd9,  1'b0, 5'b10011);
    apply("a10_b9_cin",  4'd10, 4'd9,  1'b1, 5'b10100);
    apply("all_ones",    4'd15, 4'd15, 1'b1, 5'b11111);
    apply("ones_nocin",  4'd15, 4'd15, 1'b0, 5'b11110);
    apply("ripple",      4'd15, 4'd1,  1'b0, 5'b10000);
    apply("cin_only",    4'd0,  4'd0,  1'b1, 5'b00001);
    apply("a5_b3",       4'd5,  4'd3,  1'b0, 5'b01000);
    apply("a0_b15_cin",  4'd0,  4'd15, 1'b1, 5'b10000);
    apply("max_again",   4'd15, 4'd15, 1'b1, 5'b11111);

    // Mid-cycle reset with no clock edge in between
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("reset_mid_async", out_w, 5'b00000);
    @(negedge clk);
    check("reset_mid_held", out_w, 5'b00000);
    rst_n = 1'b1;
    prev_exp = 5'd0;
    for (int i = 1; i <= LAT; i++) begin
      @(negedge clk);
      if (i < LAT) check("restart_hold", out_w, 5'b00000);
      else         check("restart_sum", out_w, 5'b11111);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
